// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding scoreboard: youngest-wins forwarding, load-use and divide stalls; HAZ_FWD_EN enables forwarding, else full interlock.
// All outputs combinational from the current scoreboard (zero latency); stall holds decode, and a busy divider freezes every stage.
module pipe_hazard_unit #(
  parameter int REG_AW     = 3,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SELW       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic              dec_rs_used,
  input  logic              dec_rt_used,
  input  logic [REG_AW-1:0] dec_dest,
  input  logic              dec_dest_valid,
  input  logic              dec_is_load,
  input  logic              dec_is_div,
  input  logic              div_done,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [SELW-1:0]   rs_fwd_sel,
  output logic [SELW-1:0]   rt_fwd_sel,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              destValid;
    logic              isLoad;
  } entry_t;

  typedef enum logic {IDLE, DIV_BUSY} state_t;

  state_t                state;
  entry_t                ent [FWD_STAGES];
  entry_t                head;
  logic [FWD_STAGES-1:0] rsHit;
  logic [FWD_STAGES-1:0] rtHit;
  logic                  loadHaz;
  logic                  hazard;
  logic                  divBusy;
  logic                  advance;

  assign divBusy = (state == DIV_BUSY);

  always_comb begin
    for (int k = 0; k < FWD_STAGES; k++) begin
      rsHit[k] = dec_rs_used && ent[k].valid && ent[k].destValid && (ent[k].dest == dec_rs);
      rtHit[k] = dec_rt_used && ent[k].valid && ent[k].destValid && (ent[k].dest == dec_rt);
    end
  end

  // Only the youngest LOAD_LAT stages hold loads whose data is not yet forwardable.
  always_comb begin
    loadHaz = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      loadHaz = loadHaz | ((rsHit[k] | rtHit[k]) & ent[k].isLoad);
    end
  end

`ifdef HAZ_FWD_EN
  assign hazard = loadHaz;

  always_comb begin
    rs_fwd_sel = '0;
    rt_fwd_sel = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (rsHit[k]) rs_fwd_sel = SELW'(k + 1);
      if (rtHit[k]) rt_fwd_sel = SELW'(k + 1);
    end
  end
`else
  assign hazard     = loadHaz | (|rsHit) | (|rtHit);
  assign rs_fwd_sel = '0;
  assign rt_fwd_sel = '0;
`endif

  assign stall   = dec_valid && (hazard || divBusy);
  assign issue   = dec_valid && !stall && !flush;
  assign wb_en   = ent[FWD_STAGES-1].valid && ent[FWD_STAGES-1].destValid && !divBusy;
  assign wb_addr = ent[FWD_STAGES-1].dest;
  assign advance = !divBusy || div_done;

  always_comb begin
    head = '0;
    if (issue) begin
      head.valid     = 1'b1;
      head.dest      = dec_dest;
      head.destValid = dec_dest_valid;
      head.isLoad    = dec_is_load;
    end
  end

  // A stall still advances older stages; only the divider freezes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      for (int k = 0; k < FWD_STAGES; k++) ent[k] <= '0;
    end else begin
      if (advance) begin
        ent[0] <= head;
        for (int k = 1; k < FWD_STAGES; k++) ent[k] <= ent[k-1];
      end
      if (!divBusy && issue && dec_is_div) state <= DIV_BUSY;
      else if (divBusy && div_done)        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: checks stall/issue/select per step and write-back order via a queue.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_rs_used, dec_rt_used, dec_dest_valid;
  logic       dec_is_load, dec_is_div, div_done, flush;
  logic [2:0] dec_rs, dec_rt, dec_dest;
  logic       stall, issue, wb_en;
  logic [1:0] rs_fwd_sel, rt_fwd_sel;
  logic [2:0] wb_addr;

  int         total = 0;
  int         bad = 0;
  logic [2:0] wbQ[$];
  bit         keepWb = 1'b1;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .dec_dest(dec_dest), .dec_dest_valid(dec_dest_valid),
    .dec_is_load(dec_is_load), .dec_is_div(dec_is_div),
    .div_done(div_done), .flush(flush),
    .stall(stall), .issue(issue),
    .rs_fwd_sel(rs_fwd_sel), .rt_fwd_sel(rt_fwd_sel),
    .wb_en(wb_en), .wb_addr(wb_addr)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    dec_valid = 0; dec_rs_used = 0; dec_rs = 0; dec_rt_used = 0; dec_rt = 0;
    dec_dest_valid = 0; dec_dest = 0; dec_is_load = 0; dec_is_div = 0;
    div_done = 0; flush = 0;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".issue"}, issue, 0);
    chk({tag, ".rssel"}, rs_fwd_sel, 0);
    chk({tag, ".rtsel"}, rt_fwd_sel, 0);
    chk({tag, ".wben"}, wb_en, 0);
    chk({tag, ".wbaddr"}, wb_addr, 0);
  endtask

  // One decode cycle: drive, sample mid-cycle, record expected write-back, then cross the edge.
  task automatic step(input string tag, input logic v,
                      input logic rsU, input logic [2:0] rs, input logic rtU, input logic [2:0] rt,
                      input logic dv, input logic [2:0] dest, input logic ld, input logic dvd,
                      input logic dd, input logic fl,
                      input logic eStall, input logic eIssue, input logic [1:0] eRs, input logic [1:0] eRt);
    dec_valid = v; dec_rs_used = rsU; dec_rs = rs; dec_rt_used = rtU; dec_rt = rt;
    dec_dest_valid = dv; dec_dest = dest; dec_is_load = ld; dec_is_div = dvd;
    div_done = dd; flush = fl;
    @(negedge clk);
    chk({tag, ".stall"}, stall, eStall);
    chk({tag, ".issue"}, issue, eIssue);
    if (eIssue) begin
      chk({tag, ".rssel"}, rs_fwd_sel, eRs);
      chk({tag, ".rtsel"}, rt_fwd_sel, eRt);
    end
    if (eIssue && dv && keepWb) wbQ.push_back(dest);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && wb_en === 1'b1) begin
      if (wbQ.size() == 0) chk("wb.unexpected", {5'd0, wb_addr}, 8'hff);
      else                 chk("wb.addr", {5'd0, wb_addr}, {5'd0, wbQ.pop_front()});
    end
  end

  initial begin
    quiet();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkAllZero("reset");
    @(posedge clk);
    #1 rst = 1'b1;

`ifdef HAZ_FWD_EN
    // r3 walks EX -> MEM -> WB; the WB-stage read happens alongside its write-back.
    step("t1.prod", 1, 0,0, 0,0, 1,3, 0,0,0,0, 0,1,0,0);
    step("t1.gap0", 1, 1,3, 0,0, 0,0, 0,0,0,0, 0,1,1,0);
    step("t1.gap1", 1, 1,3, 1,3, 0,0, 0,0,0,0, 0,1,2,2);
    step("t1.gap2", 1, 1,3, 0,0, 0,0, 0,0,0,0, 0,1,3,0);
    step("t1.gap3", 1, 1,3, 0,0, 0,0, 0,0,0,0, 0,1,0,0);
    step("t2.load", 1, 0,0, 0,0, 1,2, 1,0,0,0, 0,1,0,0);
    step("t2.use",  1, 0,0, 1,2, 0,0, 0,0,0,0, 1,0,0,0);
    step("t2.retry",1, 0,0, 1,2, 0,0, 0,0,0,0, 0,1,0,2);
    step("t3.w0",   1, 0,0, 0,0, 1,4, 0,0,0,0, 0,1,0,0);
    step("t3.mid",  1, 0,0, 0,0, 0,0, 0,0,0,0, 0,1,0,0);
    step("t3.w1",   1, 0,0, 0,0, 1,4, 0,0,0,0, 0,1,0,0);
    step("t3.young",1, 1,4, 0,0, 0,0, 0,0,0,0, 0,1,1,0);
    step("t3.unused",1,0,4, 0,4, 0,0, 0,0,0,0, 0,1,0,0);
`else
    // Full interlock: a consumer waits until the producer leaves the WB stage.
    step("t6.prod", 1, 0,0, 0,0, 1,1, 0,0,0,0, 0,1,0,0);
    for (int i = 0; i < 3; i++)
      step("t6.rs",  1, 1,1, 0,0, 1,2, 0,0,0,0, 1,0,0,0);
    step("t6.go",   1, 1,1, 0,0, 1,2, 0,0,0,0, 0,1,0,0);
    for (int i = 0; i < 3; i++)
      step("t6.rt",  1, 0,0, 1,2, 0,0, 0,0,0,0, 1,0,0,0);
    step("t6.rtgo", 1, 0,0, 1,2, 0,0, 0,0,0,0, 0,1,0,0);
    step("t6.rsoff",1, 0,2, 0,0, 0,0, 0,0,0,0, 0,1,0,0);
`endif
    for (int i = 0; i < 3; i++) idle("drain0");

    step("t5.flush", 1, 0,0, 0,0, 1,3, 0,0,0,1, 0,0,0,0);
    // r6 reaches WB just as the divide freezes the pipe; retirement shifts it out unwritten.
    keepWb = 1'b0;
    step("t5.after", 1, 1,3, 1,3, 1,6, 0,0,0,0, 0,1,0,0);
    keepWb = 1'b1;
    idle("t5.gap");
    step("t4.div",   1, 0,0, 0,0, 1,5, 0,1,0,0, 0,1,0,0);
    for (int i = 0; i < 6; i++) begin
      step("t4.busy", 1, 0,0, 0,0, 1,1, 0,0,0, logic'(i == 2), 1,0,0,0);
      chk("t4.wbfrozen", wb_en, 0);
      chk("t4.wbhold", wb_addr, 6);
    end
    step("t4.done",  1, 0,0, 0,0, 0,0, 0,0,1,0, 1,0,0,0);
    chk("t4.wbshift", wb_en, 0);
`ifdef HAZ_FWD_EN
    step("t4.use",   1, 1,5, 0,0, 0,0, 0,0,0,0, 0,1,2,0);
`else
    step("t4.use",   1, 1,5, 0,0, 0,0, 0,0,0,0, 1,0,0,0);
    step("t4.use2",  1, 1,5, 0,0, 0,0, 0,0,0,0, 1,0,0,0);
    step("t4.use3",  1, 1,5, 0,0, 0,0, 0,0,0,0, 0,1,0,0);
`endif

    keepWb = 1'b0;
    step("t5.div2",  1, 0,0, 0,0, 1,3, 0,1,0,0, 0,1,0,0);
    keepWb = 1'b1;
    step("t5.busy",  1, 0,0, 0,0, 0,0, 0,0,0,0, 1,0,0,0);
    quiet();
    rst = 1'b0;
    @(negedge clk);
    chkAllZero("t5.rst");
    @(posedge clk);
    #1 rst = 1'b1;
    step("t5.late",  1, 1,3, 0,0, 1,1, 0,0,1,0, 0,1,0,0);
    step("t5.idle",  1, 0,0, 0,0, 0,0, 0,0,0,0, 0,1,0,0);
    for (int i = 0; i < 4; i++) idle("drain1");
    chk("drain.q", wbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
